// File: rtl/vend_pkg.sv
// Shared constants for the vending payout path: coin values, default price, FSM state type.
package vend_pkg;

  localparam int unsigned NICKEL_V   = 32'd1;
  localparam int unsigned DIME_V     = 32'd2;
  localparam int unsigned QUARTER_V  = 32'd5;
  localparam int unsigned VEND_PRICE = 32'd6;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CALC    = 3'd1,
    ST_SELECT  = 3'd2,
    ST_REQ     = 3'd3,
    ST_RELEASE = 3'd4,
    ST_DONE    = 3'd5
  } vend_change_state_t;

endpackage

// File: rtl/vend_coin_select.sv
// Greedy coin picker: largest coin not exceeding rem, as one-hot {Q,D,N} plus its nickel value.
module vend_coin_select
  import vend_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0] rem,
  output logic [2:0]       coin,
  output logic [WIDTH-1:0] value
);

  // greedy choice; rem of zero yields no coin
  always_comb begin
    coin  = 3'b000;
    value = {WIDTH{1'b0}};
    if (rem >= WIDTH'(QUARTER_V)) begin
      coin  = 3'b100;
      value = WIDTH'(QUARTER_V);
    end else if (rem >= WIDTH'(DIME_V)) begin
      coin  = 3'b010;
      value = WIDTH'(DIME_V);
    end else if (rem >= WIDTH'(NICKEL_V)) begin
      coin  = 3'b001;
      value = WIDTH'(NICKEL_V);
    end else begin
      coin  = 3'b000;
      value = {WIDTH{1'b0}};
    end
  end

endmodule

// File: rtl/vend_change.sv
// Vend/refund decision and greedy change payout over a 4-phase req/ack dispenser handshake.
// Optional dispenser watchdog enabled by defining VEND_CHANGE_TIMEOUT_EN.
module vend_change
  import vend_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int PRICE = VEND_PRICE
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Load,
  input  logic [WIDTH-1:0] Credit,
  input  logic             Ack,
  output logic             DispQ,
  output logic             DispD,
  output logic             DispN,
  output logic             Vend,
  output logic             Busy,
  output logic             Done,
  output logic             Fault
);

  localparam logic [WIDTH-1:0] PRICE_W = WIDTH'(PRICE);

  vend_change_state_t state_r;
  logic [WIDTH-1:0]   rem_r;
  logic [2:0]         disp_r;
  logic               vend_r;
  logic               busy_r;
  logic               done_r;
  logic [2:0]         sel_coin_s;
  logic [WIDTH-1:0]   sel_value_s;
  logic               timeout_s;
  logic               fault_s;

  vend_coin_select #(.WIDTH(WIDTH)) u_coin_select (
    .rem   (rem_r),
    .coin  (sel_coin_s),
    .value (sel_value_s)
  );

`ifdef VEND_CHANGE_TIMEOUT_EN
  logic [7:0] wait_r;
  logic       fault_r;
  logic       waiting_s;

  assign waiting_s = ((state_r == ST_REQ) && !Ack) || ((state_r == ST_RELEASE) && Ack);
  // 255th waiting cycle is the last one tolerated
  assign timeout_s = waiting_s && (wait_r == 8'd254);
  assign fault_s   = fault_r;

  // watchdog counter for the current handshake phase, sticky fault flag
  always_ff @(posedge Clock) begin
    if (Reset) begin
      wait_r  <= 8'd0;
      fault_r <= 1'b0;
    end else begin
      wait_r  <= waiting_s ? (wait_r + 8'd1) : 8'd0;
      fault_r <= fault_r | timeout_s;
    end
  end
`else
  assign timeout_s = 1'b0;
  assign fault_s   = 1'b0;
`endif

  // payout sequencer
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r <= ST_IDLE;
      rem_r   <= {WIDTH{1'b0}};
      disp_r  <= 3'b000;
      vend_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      vend_r <= 1'b0;
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (Load && !fault_s) begin
            rem_r   <= Credit;
            vend_r  <= (Credit >= PRICE_W);
            busy_r  <= 1'b1;
            state_r <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (rem_r >= PRICE_W) begin
            rem_r <= rem_r - PRICE_W;
          end
          state_r <= ST_SELECT;
        end
        ST_SELECT: begin
          if (rem_r == {WIDTH{1'b0}}) begin
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            disp_r  <= sel_coin_s;
            state_r <= ST_REQ;
          end
        end
        ST_REQ: begin
          // rem_r is stable here, so the picker still reports the coin in flight
          if (Ack) begin
            disp_r  <= 3'b000;
            rem_r   <= rem_r - sel_value_s;
            state_r <= ST_RELEASE;
          end else if (timeout_s) begin
            disp_r  <= 3'b000;
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end
        end
        ST_RELEASE: begin
          if (!Ack) begin
            state_r <= ST_SELECT;
          end else if (timeout_s) begin
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          disp_r  <= 3'b000;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign DispQ = disp_r[2];
  assign DispD = disp_r[1];
  assign DispN = disp_r[0];
  assign Vend  = vend_r;
  assign Busy  = busy_r;
  assign Done  = done_r;
  assign Fault = fault_s;

endmodule

// File: tb/tb_vend_change.sv
// Randomized bench for vend_change with a coin-arithmetic reference model and a reactive dispenser.
module tb_vend_change;

  localparam int PRICE = 6;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       Load  = 1'b0;
  logic [5:0] Credit = 6'd0;
  logic       Ack   = 1'b0;
  logic       DispQ, DispD, DispN, Vend, Busy, Done, Fault;

  int total = 0;
  int bad   = 0;

  vend_change dut (
    .Clock (Clock), .Reset (Reset), .Load (Load), .Credit (Credit), .Ack (Ack),
    .DispQ (DispQ), .DispD (DispD), .DispN (DispN), .Vend (Vend),
    .Busy  (Busy),  .Done  (Done),  .Fault (Fault)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One full transaction; the bench plays the dispenser with random handshake delays.
  task automatic run_txn(input int credit, input bit extra_load);
    int exp_coins[$];
    int got_coins[$];
    int rem, exp_vend, exp_busy;
    int vend_cnt, vend_idx, busy_cnt, done_idx, cyc, phase, dly;
    int onehot_err, early_req;
    bit done_seen;
    logic [2:0] disp;

    rem = credit;
    exp_vend = (credit >= PRICE) ? 1 : 0;
    if (credit >= PRICE) rem = rem - PRICE;
    while (rem >= 5) begin exp_coins.push_back(5); rem = rem - 5; end
    while (rem >= 2) begin exp_coins.push_back(2); rem = rem - 2; end
    while (rem >= 1) begin exp_coins.push_back(1); rem = rem - 1; end

    exp_busy = 3;
    vend_cnt = 0; vend_idx = -1; busy_cnt = 0; done_idx = -1;
    cyc = 0; phase = 0; dly = 0; onehot_err = 0; early_req = 0; done_seen = 1'b0;

    @(negedge Clock);
    Load = 1'b1;
    Credit = 6'(credit);
    @(negedge Clock);
    Load = 1'b0;
    while (!done_seen && cyc < 3000) begin
      if (Vend) begin
        vend_cnt++;
        if (vend_idx < 0) vend_idx = cyc;
      end
      if (Busy) busy_cnt++;
      Load = (extra_load && cyc == 0) ? 1'b1 : 1'b0;
      if (extra_load && cyc == 0) Credit = 6'd20;
      disp = {DispQ, DispD, DispN};
      case (phase)
        0: if (disp != 3'b000) begin
             if (!$onehot(disp)) onehot_err++;
             got_coins.push_back(disp[2] ? 5 : (disp[1] ? 2 : 1));
             dly = $urandom_range(0, 3);
             exp_busy += dly + 3;
             phase = 1;
           end
        2: if (disp == 3'b000) begin
             dly = $urandom_range(0, 3);
             exp_busy += dly;
             phase = 3;
           end
        3: if (disp != 3'b000) early_req++;
        default: ;
      endcase
      if (phase == 1) begin
        if (dly == 0) begin Ack = 1'b1; phase = 2; end
        else dly--;
      end else if (phase == 3) begin
        if (dly == 0) begin Ack = 1'b0; phase = 0; end
        else dly--;
      end
      if (Done) begin
        done_seen = 1'b1;
        done_idx = cyc;
      end else begin
        cyc++;
        @(negedge Clock);
      end
    end
    Load = 1'b0;
    Ack  = 1'b0;

    check("done_seen", int'(done_seen), 1);
    check("vend_count", vend_cnt, exp_vend);
    if (exp_vend == 1) check("vend_latency", vend_idx, 0);
    check("coin_count", got_coins.size(), exp_coins.size());
    for (int i = 0; i < exp_coins.size(); i++)
      check($sformatf("coin[%0d]", i), (i < got_coins.size()) ? got_coins[i] : -1, exp_coins[i]);
    check("disp_onehot_err", onehot_err, 0);
    check("req_while_ack_high", early_req, 0);
    check("busy_cycles", busy_cnt, exp_busy);
    check("done_cycle", done_idx, exp_busy - 1);
    @(negedge Clock);
    check("done_pulse_end", int'(Done), 0);
    check("busy_end", int'(Busy), 0);
    check("fault_low", int'(Fault), 0);
  endtask

  initial begin
    int seen;

    repeat (2) @(negedge Clock);
    check("reset_outputs", int'({DispQ, DispD, DispN, Vend, Busy, Done, Fault}), 0);
    Reset = 1'b0;

    run_txn(6, 1'b0);
    run_txn(19, 1'b0);
    run_txn(4, 1'b0);
    run_txn(0, 1'b0);
    run_txn(20, 1'b1);
    run_txn(63, 1'b0);

    // Reset in the middle of a quarter request
    @(negedge Clock);
    Load = 1'b1; Credit = 6'd19;
    @(negedge Clock);
    Load = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      if (DispQ) seen = 1;
      else @(negedge Clock);
    end
    check("rst_pre_dispq", seen, 1);
    Reset = 1'b1;
    @(negedge Clock);
    check("rst_mid_outputs", int'({DispQ, DispD, DispN, Vend, Busy, Done, Fault}), 0);
    Reset = 1'b0;
    @(negedge Clock);
    check("rst_mid_idle", int'({DispQ, DispD, DispN, Busy, Done}), 0);
    run_txn(6, 1'b0);

    for (int n = 0; n < 40; n++)
      run_txn(int'($urandom_range(0, 63)), 1'(($urandom_range(0, 3) == 0)));

`ifdef VEND_CHANGE_TIMEOUT_EN
    begin
      int ncnt;
      int busy_seen;
      bit ended;
      @(negedge Clock);
      Load = 1'b1; Credit = 6'd7;
      @(negedge Clock);
      Load = 1'b0;
      ncnt = 0; ended = 1'b0;
      for (int i = 0; i < 400 && !ended; i++) begin
        if (DispN) ncnt++;
        else if (ncnt > 0) ended = 1'b1;
        if (!ended) @(negedge Clock);
      end
      check("to_dispn_cycles", ncnt, 255);
      check("to_fault", int'(Fault), 1);
      check("to_done", int'(Done), 1);
      @(negedge Clock);
      check("to_done_pulse_end", int'({Done, Busy}), 0);
      Load = 1'b1; Credit = 6'd6;
      @(negedge Clock);
      Load = 1'b0;
      busy_seen = 0;
      for (int i = 0; i < 6; i++) begin
        if (Busy || Vend) busy_seen++;
        @(negedge Clock);
      end
      check("to_load_ignored", busy_seen, 0);
      check("to_fault_sticky", int'(Fault), 1);
      Reset = 1'b1;
      @(negedge Clock);
      Reset = 1'b0;
      check("to_fault_cleared", int'(Fault), 0);
      run_txn(6, 1'b0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
